mux_2to1: RTL and testbench

Width-parameterised 2:1 multiplexer with a combinational output, plus a registered copy of the output and select-activity monitoring. It is a datapath steering primitive: `out` follows the inputs with zero clock latency; the registered side-band outputs serve timing-closed consumers and debug counters. Default data width is 4 bits.

---
 rtl/mux_2to1.sv | 58 +++++
 tb/tb_mux_2to1.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mux_2to1.sv
// 2:1 data mux with zero-latency output plus registered copy, select monitor and saturating switch counter.
// Latency: out 0 cycles, registered side-band 1 cycle; no backpressure, always accepts inputs.
module mux_2to1 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_q,
  output logic             sel_chg,
  output logic [CNT_W-1:0] switch_cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_prev_q, sel_prev_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    out = sel ? b : a;
  end

  // Counter saturates at all-ones so debug readers never see a wrap.
  always_comb begin
    data_d     = out;
    sel_prev_d = sel;
    chg_d      = (sel != sel_prev_q);
    cnt_d      = cnt_q;
    if (chg_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      sel_prev_q <= 1'b0;
      chg_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      data_q     <= data_d;
      sel_prev_q <= sel_prev_d;
      chg_q      <= chg_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_q      = data_q;
  assign sel_q      = sel_prev_q;
  assign sel_chg    = chg_q;
  assign switch_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: reference model checked every cycle plus literal spot checks.
module tb_mux_2to1;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             sel = 1'b0;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;
  logic             sel_chg;
  logic [CNT_W-1:0] switch_cnt;

  int tests = 0;
  int fails = 0;

  // Model state: what the registered outputs must hold.
  int m_out_q = 0;
  int m_sel_q = 0;
  int m_chg   = 0;
  int m_cnt   = 0;

  mux_2to1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .sel(sel),
    .out(out), .out_q(out_q), .sel_q(sel_q), .sel_chg(sel_chg),
    .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_out_q = 0; m_sel_q = 0; m_chg = 0; m_cnt = 0;
    end else begin
      m_chg   = (int'(sel) != m_sel_q) ? 1 : 0;
      if (m_chg == 1 && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
      m_sel_q = int'(sel);
      m_out_q = (sel == 1'b1) ? int'(b) : int'(a);
    end
  end

  always @(negedge clk) begin
    check("cmp_out",        int'(out),        (sel == 1'b1) ? int'(b) : int'(a));
    check("cmp_out_q",      int'(out_q),      m_out_q);
    check("cmp_sel_q",      int'(sel_q),      m_sel_q);
    check("cmp_sel_chg",    int'(sel_chg),    m_chg);
    check("cmp_switch_cnt", int'(switch_cnt), m_cnt);
  end

  // Drive inputs just after a rising edge, then advance past the next edge.
  task automatic tick(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vs);
    a = va; b = vb; sel = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // Combinational path with reset held.
    #1;
    a = 4'b0000; b = 4'b1111; sel = 1'b0;
    #10 check("comb_sel0", int'(out), 0);
    sel = 1'b1;
    #10 check("comb_sel1", int'(out), 15);
    check("reset_out_q", int'(out_q), 0);
    check("reset_cnt",   int'(switch_cnt), 0);
    check("reset_chg",   int'(sel_chg), 0);
    check("reset_sel_q", int'(sel_q), 0);

    for (int i = 0; i < 16; i++) begin
      sel = 1'b0; b = 4'd5; a = WIDTH'(i);
      #2 check("sweep_a", int'(out), i);
    end
    for (int i = 0; i < 16; i++) begin
      sel = 1'b1; a = 4'd9; b = WIDTH'(i);
      #2 check("sweep_b", int'(out), i);
    end

    // Registered path after reset.
    sel = 1'b0;
    do_reset();
    tick(4'd3, 4'd12, 1'b0);
    check("reg1_out_q", int'(out_q), 3);
    check("reg1_chg",   int'(sel_chg), 0);
    check("reg1_cnt",   int'(switch_cnt), 0);
    tick(4'd3, 4'd12, 1'b1);
    check("reg2_out_q", int'(out_q), 12);
    check("reg2_chg",   int'(sel_chg), 1);
    check("reg2_cnt",   int'(switch_cnt), 1);
    tick(4'd3, 4'd12, 1'b0);
    check("reg3_out_q", int'(out_q), 3);
    check("reg3_chg",   int'(sel_chg), 1);
    check("reg3_cnt",   int'(switch_cnt), 2);
    check("reg3_sel_q", int'(sel_q), 0);

    // Saturation: 300 toggles from a fresh reset.
    do_reset();
    for (int i = 0; i < 300; i++) tick(4'd1, 4'd2, (i % 2 == 0) ? 1'b1 : 1'b0);
    check("sat_cnt", int'(switch_cnt), 255);
    tick(4'd1, 4'd2, 1'b1);
    tick(4'd1, 4'd2, 1'b0);
    check("sat_hold", int'(switch_cnt), 255);
    check("sat_chg",  int'(sel_chg), 1);

    // Build switch_cnt=7, out_q=12, then reset between edges.
    do_reset();
    for (int i = 0; i < 7; i++) tick(4'd3, 4'd12, (i % 2 == 0) ? 1'b1 : 1'b0);
    check("pre_rst_cnt",   int'(switch_cnt), 7);
    check("pre_rst_out_q", int'(out_q), 12);
    #2 rst = 1'b1;
    #1;
    check("arst_out_q", int'(out_q), 0);
    check("arst_sel_q", int'(sel_q), 0);
    check("arst_chg",   int'(sel_chg), 0);
    check("arst_cnt",   int'(switch_cnt), 0);
    check("arst_out",   int'(out), 12);
    #1 rst = 1'b0;
    // Release with sel=1: first edge is a transition.
    @(posedge clk); #1;
    check("rel_chg",   int'(sel_chg), 1);
    check("rel_cnt",   int'(switch_cnt), 1);
    check("rel_out_q", int'(out_q), 12);
    tick(4'd3, 4'd12, 1'b0);
    check("rel2_cnt",  int'(switch_cnt), 2);
    tick(4'd3, 4'd12, 1'b0);
    check("rel3_chg",  int'(sel_chg), 0);
    check("rel3_cnt",  int'(switch_cnt), 2);

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
